// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// registered status flags, occupancy output and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic                         re,
  output logic [DATA_WIDTH-1:0]        r_data,
  output logic                         r_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overrun,
  output logic                         underrun,
  input  logic                         clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [CW-1:0]         count_nxt;

  // Accept logic: a pop at full frees the slot the simultaneous push needs.
  always_comb begin
    rd_ok     = re & ~empty;
    wr_ok     = we & (~full | rd_ok);
    count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
  end

  // Storage array; deliberately not reset so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (rst && wr_ok) begin
      mem[wp] <= w_data;
    end
  end

  // Pointers, occupancy and status flags derived from the next count so the
  // flags are always consistent with the count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      count        <= count_nxt;
      full         <= (count_nxt == FULL_LVL);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_LVL);
      almost_empty <= (count_nxt <= AE_LVL);
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      overrun  <= (overrun  & ~clr_err) | (we & full & ~rd_ok);
      underrun <= (underrun & ~clr_err) | (re & empty);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head of queue presented directly; forced to zero while nothing is
      // stored so stale RAM contents never appear on the output.
      always_comb begin
        r_valid = ~empty;
        r_data  = empty ? '0 : mem[rp];
      end
    end else begin : g_std
      // Registered read port: data lands one cycle after the accepted read.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= rd_ok;
          if (rd_ok) r_data <= mem[rp];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and fall-through instances share one
// stimulus stream and are checked against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] w_data = '0;

  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_rvalid, f_rvalid;
  logic [CW-1:0] s_count, f_count;
  logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ov, m_un, m_rvalid;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT),
                    .AE_THRESH(AET), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .we(we), .w_data(w_data), .re(re),
    .r_data(s_rdata), .r_valid(s_rvalid), .count(s_count), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .overrun(s_ov), .underrun(s_un), .clr_err(clr_err));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AFT),
                    .AE_THRESH(AET), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .we(we), .w_data(w_data), .re(re),
    .r_data(f_rdata), .r_valid(f_rvalid), .count(f_count), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .overrun(f_ov), .underrun(f_un), .clr_err(clr_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Advance the model by one clock using the FIFO's acceptance rules.
  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic c, input logic rs);
    int  n;
    bit  rd, wr;
    if (!rs) begin
      q.delete();
      m_ov = 1'b0; m_un = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      return;
    end
    n  = q.size();
    rd = r && (n > 0);
    wr = w && ((n < DEPTH) || rd);
    m_ov = (m_ov && !c) || (w && (n == DEPTH) && !rd);
    m_un = (m_un && !c) || (r && (n == 0));
    m_rvalid = rd;
    if (rd) m_rdata = q.pop_front();
    if (wr) q.push_back(d);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count",        32'(s_count), 32'(n));
    check("full",         32'(s_full),  32'(n == DEPTH));
    check("empty",        32'(s_empty), 32'(n == 0));
    check("almost_full",  32'(s_af),    32'(n >= AFT));
    check("almost_empty", 32'(s_ae),    32'(n <= AET));
    check("overrun",      32'(s_ov),    32'(m_ov));
    check("underrun",     32'(s_un),    32'(m_un));
    check("r_valid",      32'(s_rvalid), 32'(m_rvalid));
    check("r_data",       32'(s_rdata), 32'(m_rdata));
    check("fwft_count",   32'(f_count), 32'(n));
    check("fwft_r_valid", 32'(f_rvalid), 32'(n != 0));
    check("fwft_r_data",  32'(f_rdata), (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic c, input logic rs);
    we = w; w_data = d; re = r; clr_err = c; rst = rs;
    model_step(w, d, r, c, rs);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic fill_to(input int lvl);
    while (q.size() < lvl) cyc(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    while (q.size() > 0) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int pw, pr;
    m_ov = 1'b0; m_un = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

    // Reset, then fill with 0x01..0x10 and read back in order
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Overrun at full, then clear
    fill_to(DEPTH);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    // Error event coinciding with clear keeps the flag set
    cyc(1'b1, 8'hAB, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Simultaneous push/pop at full across pointer wrap
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, 1'b1);
    drain();

    // Simultaneous push/pop at empty: write wins, underrun set
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Fall-through: single word visible without a read, then popped
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Mid-operation reset discards data
    fill_to(9);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Randomised phases biased toward filling, draining and balanced traffic
    for (int i = 0; i < 1800; i++) begin
      case ((i / 90) % 3)
        0:       begin pw = 80; pr = 25; end
        1:       begin pw = 25; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      cyc(($urandom_range(0, 99) < pw), DW'($urandom), ($urandom_range(0, 99) < pr),
          ($urandom_range(0, 99) < 4), !($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
